// File: rtl/branch_redirect_unit.sv
// branch_redirect_unit: turns branch mispredict / CP0 exception flushes into a held fetch redirect,
// kill and checkpoint-restore pulses, and queues predictor training records.
module branch_redirect_unit #(
  parameter int CP_W  = 16,
  parameter int RA_W  = 4,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sba_flush_i,
  input  logic [31:0]     sba_err_vaddr_i,
  input  logic [31:0]     sba_corr_dest_i,
  input  logic            sba_corr_take_i,
  input  logic [CP_W-1:0] sba_check_point_i,
  input  logic [RA_W-1:0] sba_repair_action_i,
  input  logic            cp0_exc_occur_i,
  input  logic [31:0]     cp0_exc_dest_i,
  output logic            redir_valid_o,
  output logic [31:0]     redir_pc_o,
  input  logic            redir_ready_i,
  output logic            flush_frontend_o,
  output logic            ckpt_valid_o,
  output logic [CP_W-1:0] ckpt_o,
  output logic [RA_W-1:0] repair_action_o,
  output logic            upd_valid_o,
  output logic [31:0]     upd_pc_o,
  output logic [31:0]     upd_target_o,
  output logic            upd_take_o,
  input  logic            upd_ready_i,
  output logic [7:0]      upd_drop_cnt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state, state_nx;
  logic [31:0] pc_nx, br_pc;
  logic flush_nx, ckpt_nx, accept, eff_idle, push, pop, full, do_push;
  logic [64:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  assign redir_valid_o = state == HOLD;
  assign accept = redir_valid_o && redir_ready_i;
  // an accepted redirect frees the unit in the same cycle a new event arrives
  assign eff_idle = state == IDLE || accept;
  assign br_pc = sba_corr_take_i ? sba_corr_dest_i : sba_err_vaddr_i + 32'd8;
  assign push = sba_flush_i && !cp0_exc_occur_i && eff_idle;
  assign upd_valid_o = count != '0;
  assign full = count == FULL;
  assign pop = upd_valid_o && upd_ready_i;
  assign do_push = push && (!full || pop);
  assign {upd_pc_o, upd_target_o, upd_take_o} = upd_valid_o ? mem[rd_ptr] : '0;
  always_comb begin
    state_nx = state;
    pc_nx = redir_pc_o;
    flush_nx = 1'b0;
    ckpt_nx = 1'b0;
    if (cp0_exc_occur_i) begin
      state_nx = HOLD;
      pc_nx = cp0_exc_dest_i;
      flush_nx = 1'b1;
    end else if (sba_flush_i && eff_idle) begin
      state_nx = HOLD;
      pc_nx = br_pc;
      flush_nx = 1'b1;
      ckpt_nx = 1'b1;
    end else if (accept) state_nx = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      redir_pc_o <= '0;
      flush_frontend_o <= 1'b0;
      ckpt_valid_o <= 1'b0;
      ckpt_o <= '0;
      repair_action_o <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      upd_drop_cnt_o <= '0;
    end else begin
      state <= state_nx;
      redir_pc_o <= pc_nx;
      flush_frontend_o <= flush_nx;
      ckpt_valid_o <= ckpt_nx;
      if (ckpt_nx) begin
        ckpt_o <= sba_check_point_i;
        repair_action_o <= sba_repair_action_i;
      end
      if (do_push) begin
        mem[wr_ptr] <= {sba_err_vaddr_i, sba_corr_dest_i, sba_corr_take_i};
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, pop};
      if (push && !do_push && upd_drop_cnt_o != 8'hFF) upd_drop_cnt_o <= upd_drop_cnt_o + 8'd1;
    end
  end
endmodule
